tile_stim_seq: RTL and testbench

Pattern sequencer that sits directly upstream of a microtile and drives its 8-bit ui_in bus. It also receives the tile's 8-bit uo_out bus back. A 16-entry pattern table is loaded through a write port and played out with a programmable hold time per step. After each step the tile response is folded into a 16-bit signature, so a bench or on-chip controller can check a tile with a single compare.

---
 rtl/tile_stim_seq_if.sv | 42 ++++
 rtl/tile_stim_seq.sv | 169 ++++++++++++++++
 tb/tb_tile_stim_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_stim_seq_if.sv
// ============================================================================
//  Module   : tile_stim_seq_if
//  Desc     : Control, pattern-table write and tile-facing bus of the sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tile_stim_seq_if #(
  parameter int ADDR_W = 4,
  parameter int HOLD_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] last_addr;
  logic [HOLD_W-1:0] hold;
  logic [7:0]        tile_ui;
  logic [7:0]        tile_uo;
  logic              busy;
  logic              done;
  logic [15:0]       sig;
  logic [7:0]        step_cnt;

  // Controller / bench side
  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_en, last_addr, hold,
    output tile_uo,
    input  tile_ui, busy, done, sig, step_cnt
  );

  // Sequencer side
  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_en, last_addr, hold,
    input  tile_uo,
    output tile_ui, busy, done, sig, step_cnt
  );
endinterface

`default_nettype wire

// File: rtl/tile_stim_seq.sv
// ============================================================================
//  Module   : tile_stim_seq
//  Desc     : Plays a 16-entry pattern table into a microtile with per-step
//             hold and folds the tile response into a 16-bit signature.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_stim_seq #(
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  tile_stim_seq_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_HOLD   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic              r_loop;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] r_cnt;
  logic [7:0]        r_tile_ui;
  logic [15:0]       r_sig;
  logic [7:0]        r_step_cnt;

  logic              w_busy;
  logic              w_wr_accept;
  logic              w_load_cfg;
  logic              w_apply;
  logic              w_count;
  logic              w_sample;
  logic              w_at_last;

  assign w_busy      = (r_state != S_IDLE);
  assign w_wr_accept = bus.wr_en && !w_busy;
  assign w_at_last   = (r_addr == r_last);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stop has priority over every transition, including start in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load_cfg  = 1'b0;
    w_apply     = 1'b0;
    w_count     = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_load_cfg  = 1'b1;
          w_state_nxt = S_APPLY;
        end
      end
      S_APPLY: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_apply     = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_count = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_sample = 1'b1;
          if (!w_at_last || r_loop) begin
            w_state_nxt = S_APPLY;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ pattern table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_wr_accept) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_last     <= '0;
      r_loop     <= 1'b0;
      r_hold     <= '0;
      r_cnt      <= '0;
      r_tile_ui  <= 8'h00;
      r_sig      <= 16'h0000;
      r_step_cnt <= 8'h00;
    end else begin
      if (w_load_cfg) begin
        r_addr     <= '0;
        r_last     <= bus.last_addr;
        r_loop     <= bus.loop_en;
        r_hold     <= bus.hold;
        r_sig      <= 16'h0000;
        r_step_cnt <= 8'h00;
      end
      if (w_apply) begin
        r_tile_ui <= r_mem[r_addr];
        r_cnt     <= r_hold;
      end
      if (w_count) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_sample) begin
        r_sig      <= {r_sig[14:0], r_sig[15]} ^ {8'h00, bus.tile_uo};
        r_step_cnt <= r_step_cnt + 8'd1;
        // Wrapping to 0 at the last entry is harmless for non-looping runs.
        r_addr     <= w_at_last ? '0 : r_addr + 1'b1;
      end
    end
  end

  assign bus.tile_ui  = r_tile_ui;
  assign bus.busy     = w_busy;
  assign bus.done     = (r_state == S_DONE);
  assign bus.sig      = r_sig;
  assign bus.step_cnt = r_step_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tile_stim_seq.sv
// ============================================================================
//  Module   : tb_tile_stim_seq
//  Desc     : Self-checking bench for tile_stim_seq with a loopback tile model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_stim_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] uo_xor;
  int         checks = 0;
  int         errors = 0;

  logic [7:0]  mem_m [16];
  logic [7:0]  prev_ui;
  logic [15:0] esig [0:1023];

  tile_stim_seq_if bus ();

  // Tile model: response is the applied pattern with a per-run XOR key.
  assign bus.tile_uo = bus.tile_ui ^ uo_xor;

  always #5 clk = ~clk;

  tile_stim_seq #(.DEPTH(16), .HOLD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          lp;
    logic [3:0]  la;
    logic [7:0]  hd;
    logic [7:0]  ux;
    int          stop_at;
    logic [15:0] e_sig;
    logic [7:0]  e_cnt;
    logic [7:0]  e_ui;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%h required=0x%h", nm, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_write(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    mem_m[a]  = d;
  endtask

  // Cycle c=0 is the first cycle after start is accepted. Expected values come
  // from step arithmetic: each step lasts hold+3 cycles, pattern k shows from
  // cycle k*P+1, and the k-th signature term is visible from cycle (k+1)*P.
  task automatic run(input bit lp, input logic [3:0] la, input logic [7:0] hd,
                     input logic [7:0] ux, input int stop_at, input bit busy_wr,
                     input bit start_wr, input logic [7:0] swd,
                     output logic [15:0] f_sig, output logic [7:0] f_cnt,
                     output logic [7:0] f_ui);
    int P, L, end_c, n, idx, cc;
    logic [15:0] e_sig;
    logic [7:0]  e_ui, e_cnt;
    bit          e_busy, e_done;
    P = int'(hd) + 3;
    L = int'(la) + 1;
    uo_xor = ux;
    if (start_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd0;
      bus.wr_data = swd;
      mem_m[0]    = swd;
    end
    bus.loop_en   = lp;
    bus.last_addr = la;
    bus.hold      = hd;
    bus.start     = 1'b1;
    end_c = (stop_at >= 0) ? stop_at + 1 : L * P + 1;
    esig[0] = 16'h0000;
    for (int k = 1; k <= end_c / P + 1 && k < 1024; k++) begin
      esig[k] = {esig[k-1][14:0], esig[k-1][15]} ^ {8'h00, mem_m[(k-1) % L] ^ ux};
    end
    e_ui  = prev_ui;
    f_sig = 16'h0;
    f_cnt = 8'h0;
    f_ui  = 8'h0;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int c = 0; c <= end_c; c++) begin
      if (busy_wr && c < end_c) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'($urandom_range(0, 15));
        bus.wr_data = 8'($urandom);
      end
      if (c == stop_at) bus.stop = 1'b1;
      cc = (stop_at >= 0 && c == stop_at + 1) ? stop_at : c;
      n = cc / P;
      if (!lp && n > L) n = L;
      if (cc == 0) begin
        e_ui = prev_ui;
      end else begin
        idx = (cc - 1) / P;
        if (!lp && idx > L - 1) idx = L - 1;
        e_ui = mem_m[idx % L];
      end
      e_sig  = esig[n];
      e_cnt  = 8'(n);
      e_busy = lp ? 1'b1 : (cc <= L * P);
      e_done = !lp && (cc == L * P);
      if (cc != c) begin
        e_busy = 1'b0;
        e_done = 1'b0;
      end
      @(negedge clk);
      chk("tile_ui",  c, 16'(bus.tile_ui),  16'(e_ui));
      chk("busy",     c, 16'(bus.busy),     16'(e_busy));
      chk("done",     c, 16'(bus.done),     16'(e_done));
      chk("sig",      c, bus.sig,           e_sig);
      chk("step_cnt", c, 16'(bus.step_cnt), 16'(e_cnt));
      f_sig = bus.sig;
      f_cnt = bus.step_cnt;
      f_ui  = bus.tile_ui;
      tick();
      bus.stop  = 1'b0;
      bus.wr_en = 1'b0;
    end
    prev_ui = e_ui;
  endtask

  initial begin
    logic [15:0] fs;
    logic [7:0]  fc, fu;
    bit          lp;
    logic [3:0]  la;
    logic [7:0]  hd;
    int          sa, lim;

    // lp, last, hold, xor, stop_at, sig, step_cnt, tile_ui (hand-derived)
    vecs[0] = '{1'b0, 4'd1, 8'd0, 8'h00, -1, 16'h0176, 8'd2, 8'h3C};
    vecs[1] = '{1'b0, 4'd0, 8'd4, 8'h00, -1, 16'h00A5, 8'd1, 8'hA5};
    vecs[2] = '{1'b0, 4'd1, 8'd2, 8'hFF, -1, 16'h0077, 8'd2, 8'h3C};
    vecs[3] = '{1'b1, 4'd1, 8'd0, 8'h00, 18, 16'h13CE, 8'd6, 8'h3C};
    vecs[4] = '{1'b0, 4'd1, 8'd1, 8'h00,  7, 16'h00A5, 8'd1, 8'h3C};
    vecs[5] = '{1'b0, 4'd0, 8'd0, 8'h0F, -1, 16'h00AA, 8'd1, 8'hA5};

    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
    bus.last_addr = '0; bus.hold = '0;
    uo_xor  = 8'h00;
    prev_ui = 8'h00;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;

    #2;
    chk("rst_tile_ui",  0, 16'(bus.tile_ui),  16'h0);
    chk("rst_busy",     0, 16'(bus.busy),     16'h0);
    chk("rst_done",     0, 16'(bus.done),     16'h0);
    chk("rst_sig",      0, bus.sig,           16'h0);
    chk("rst_step_cnt", 0, 16'(bus.step_cnt), 16'h0);
    tick();
    rst_n = 1'b1;

    idle_write(4'd0, 8'hA5);
    idle_write(4'd1, 8'h3C);

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].lp, vecs[i].la, vecs[i].hd, vecs[i].ux, vecs[i].stop_at,
          1'b0, 1'b0, 8'h00, fs, fc, fu);
      chk("tbl_sig",      i, fs,     vecs[i].e_sig);
      chk("tbl_step_cnt", i, 16'(fc), 16'(vecs[i].e_cnt));
      chk("tbl_tile_ui",  i, 16'(fu), 16'(vecs[i].e_ui));
      tick();
    end

    // Writes while busy must not reach the table; the next run replays 0xA5.
    run(1'b0, 4'd1, 8'd2, 8'h00, -1, 1'b1, 1'b0, 8'h00, fs, fc, fu);
    run(1'b0, 4'd1, 8'd0, 8'h00, -1, 1'b0, 1'b0, 8'h00, fs, fc, fu);
    chk("protect_sig", 0, fs, 16'h0176);

    // Write in the start cycle is played as entry 0.
    run(1'b0, 4'd0, 8'd0, 8'h00, -1, 1'b0, 1'b1, 8'h5E, fs, fc, fu);
    chk("startwr_ui",  0, 16'(fu), 16'h005E);
    chk("startwr_sig", 0, fs,      16'h005E);

    // Reset asserted mid-HOLD.
    bus.loop_en = 1'b0; bus.last_addr = 4'd0; bus.hold = 8'd10; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_busy", 0, 16'(bus.busy), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tile_ui",  0, 16'(bus.tile_ui),  16'h0);
    chk("mid_rst_busy",     0, 16'(bus.busy),     16'h0);
    chk("mid_rst_sig",      0, bus.sig,           16'h0);
    chk("mid_rst_step_cnt", 0, 16'(bus.step_cnt), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    prev_ui = 8'h00;

    // Whole table after reset must play zeros.
    run(1'b0, 4'd15, 8'd0, 8'h00, -1, 1'b0, 1'b0, 8'h00, fs, fc, fu);
    chk("zero_sig",     0, fs,      16'h0000);
    chk("zero_tile_ui", 0, 16'(fu), 16'h0000);
    chk("zero_cnt",     0, 16'(fc), 16'd16);

    // start and stop together in IDLE: stop wins.
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    chk("start_stop_busy", 0, 16'(bus.busy), 16'h0);
    tick();

    // step_cnt wrap: 260 steps.
    idle_write(4'd0, 8'hA5);
    idle_write(4'd1, 8'h3C);
    run(1'b1, 4'd1, 8'd0, 8'h00, 780, 1'b0, 1'b0, 8'h00, fs, fc, fu);
    chk("wrap_cnt", 0, 16'(fc), 16'd4);

    // Randomized runs against the step-arithmetic model.
    for (int r = 0; r < 40; r++) begin
      for (int w = 0; w < 4; w++) begin
        idle_write(4'($urandom_range(0, 15)), 8'($urandom));
      end
      lp  = 1'($urandom_range(0, 1));
      la  = 4'($urandom_range(0, 15));
      hd  = 8'($urandom_range(0, 6));
      lim = (int'(la) + 1) * (int'(hd) + 3);
      if (lp) begin
        sa = $urandom_range(0, (lim * 3 > 200) ? 200 : lim * 3);
      end else begin
        sa = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, lim));
      end
      run(lp, la, hd, 8'($urandom), sa, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 8'($urandom), fs, fc, fu);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
